rat_io_hub: RTL and testbench
=============================

# rat_io_hub

Parametrised port-I/O hub between the RAT CPU (`IN_PORT`/`OUT_PORT`/`PORT_ID`/`IO_STRB`) and the board peripherals. It provides:
- an N-channel input mux;
- an M-register output bank;
- a VGA framebuffer write port with optional pixel auto-increment;
- a maskable, edge-triggered multi-source interrupt controller.

It is the generalised replacement for hand-written per-board port decode.

## Interface
Parameters:
- NUM_IN, 4, input channels at port IDs IN_BASE..IN_BASE+NUM_IN-1 (1..16)
- NUM_OUT, 4, output registers at port IDs OUT_BASE..OUT_BASE+NUM_OUT-1 (1..16)
- NUM_IRQ, 4, interrupt sources (1..8)
- IN_BASE, 8'h20, first input port ID
- OUT_BASE, 8'h40, first output port ID
- VGA_XMAX, 80, pixels per row; X wraps at this value
- VGA_YMAX, 60, rows; Y wraps at this value

Ports:
- CLK  in  1  system clock; every CPU-facing signal is sampled on it
- RST  in  1  synchronous, active-high reset
- PORT_ID  in  8  CPU port address
- OUT_PORT  in  8  CPU write data
- IO_STRB  in  1  CPU write strobe; may stay high for more than one CLK cycle
- IN_PORT  out  8  read data to CPU; combinational
- IN_DATA  in  8*NUM_IN  input channel k occupies bits [8k+7:8k]
- OUT_DATA  out  8*NUM_OUT  output register k occupies bits [8k+7:8k]
- VGA_WA  out  13  framebuffer address; {Y[5:0], X[6:0]}
- VGA_WD  out  8  framebuffer pixel data
- VGA_WE  out  1  framebuffer write enable; single-cycle pulse
- VGA_RD  in  8  framebuffer read data
- IRQ_SRC  in  NUM_IRQ  interrupt request lines; level inputs, synchronous to CLK
- INT  out  1  interrupt request to the CPU

## Operation
- Write event: occurs on the first CLK cycle where IO_STRB=1 and the registered IO_STRB=0. A strobe held for k cycles produces exactly one write. PORT_ID and OUT_PORT are sampled in the event cycle.
- Output bank: a write to OUT_BASE+k (k<NUM_OUT) loads register k. Writes to unmapped IDs are ignored.
- VGA ports:
  - 8'h90 (HADDR) loads Y from OUT_PORT[5:0].
  - 8'h91 (LADDR) loads X from OUT_PORT[6:0].
  - 8'h92 (COLOR) loads VGA_WD and pulses VGA_WE on the next cycle.
  - 8'h93 reads VGA_RD.
- IRQ:
  - IRQ_SRC is registered once. A rising edge on source k sets pending[k].
  - 8'hF0: read returns pending (zero-extended); write is write-1-to-clear.
  - 8'hF1: mask register, read/write; only bits [NUM_IRQ-1:0] are writable.
  - If a set and a clear of the same bit happen in the same cycle, the set wins.
  - INT is a register equal to |(pending & mask).
- Read mux:
  - IN_BASE+k returns IN_DATA channel k.
  - OUT_BASE+k returns register k (read-back).
  - 8'h93, 8'hF0 and 8'hF1 return as described above.
  - Every other ID returns 8'h00.
- Port-ID overlap between ranges is illegal. The bench asserts it never occurs.

## Timing
- Reset values: OUT_DATA=0, VGA_WA=0, VGA_WD=0, VGA_WE=0, pending=0, mask=0, INT=0, registered strobe=0, registered IRQ_SRC=0.
- A write event at edge n is visible on OUT_DATA, VGA_WA, VGA_WD, mask and pending after edge n.
- VGA_WE is high for exactly the cycle after edge n. VGA_WA and VGA_WD are stable during that pulse.
- IRQ latency:
  - IRQ_SRC rising before edge n: pending set at edge n+1, INT high after edge n+2 (if masked in).
  - Clearing pending at edge n drops INT after edge n+1.
- IN_PORT has zero latency from PORT_ID or any data input.
- RST asserted mid-strobe: all state resets and the strobe register clears. If IO_STRB is still high when RST deasserts, the next cycle counts as a new write event.

## Configuration
- RAT_IO_VGA_AUTOINC_EN defined:
  - On the cycle VGA_WE pulses, X increments.
  - When X reaches VGA_XMAX-1 it wraps to 0 and Y increments.
  - When Y reaches VGA_YMAX-1 and wraps, Y returns to 0.
  - An explicit HADDR/LADDR write overrides this and takes effect as usual.
- Undefined: X and Y change only through explicit HADDR/LADDR writes.

## Structure
- Package rat_io_pkg holds:
  - port-ID localparams: VGA_HADDR_ID 8'h90, VGA_LADDR_ID 8'h91, VGA_COLOR_ID 8'h92, VGA_READ_ID 8'h93, IRQ_PEND_ID 8'hF0, IRQ_MASK_ID 8'hF1;
  - VGA address width 13 and X/Y field widths 7/6.
- Sub-module rat_irq_ctrl (parameter NUM_IRQ) contains the source edge detect, pending, mask and INT register.
- Everything else stays in rat_io_hub.

## Test plan
- Reset, then IO_STRB high for 2 cycles with PORT_ID=8'h41, OUT_PORT=8'hA5 -> OUT_DATA[15:8]=8'hA5 exactly once; reading PORT_ID 8'h41 returns 8'hA5; reading 8'h7F returns 8'h00.
- Write 8'h90=8'h05, then 8'h91=8'h4F, then 8'h92=8'h1C -> VGA_WA=13'h02CF, VGA_WD=8'h1C, one-cycle VGA_WE.
- With AUTOINC_EN: X=79, Y=59, three COLOR writes -> VGA_WE pulses at addresses {59,79}, {0,0}, {0,1}. Without AUTOINC_EN: all three writes go to {59,79}.
- Mask=8'h05, pulse IRQ_SRC[2] -> INT high two cycles later and pending reads 8'h04. Pulse IRQ_SRC[1] -> pending reads 8'h06 with INT unchanged. Write 8'hF0=8'h04 -> INT low; pending reads 8'h02.
- IRQ_SRC[0] rising edge in the same cycle as a write 8'hF0=8'h01 -> pending[0] stays set.
- RST during an IO_STRB burst -> all outputs return to 0. IO_STRB still high after RST deasserts -> one new write.

Source files
------------

// File: rtl/rat_io_pkg.sv
// Shared port-ID map and VGA address geometry for the RAT I/O hub.
// Imported by rat_io_hub.
package rat_io_pkg;

  localparam logic [7:0] VGA_HADDR_ID = 8'h90;
  localparam logic [7:0] VGA_LADDR_ID = 8'h91;
  localparam logic [7:0] VGA_COLOR_ID = 8'h92;
  localparam logic [7:0] VGA_READ_ID  = 8'h93;
  localparam logic [7:0] IRQ_PEND_ID  = 8'hF0;
  localparam logic [7:0] IRQ_MASK_ID  = 8'hF1;

  localparam int VGA_AW = 13;
  localparam int VGA_XW = 7;
  localparam int VGA_YW = 6;

endpackage

// File: rtl/rat_irq_ctrl.sv
// Edge-triggered, maskable interrupt controller for the RAT I/O hub.
// Sources are registered, edge-detected into pending; INT is registered.
module rat_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               pend_clr_we,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] wdata,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               int_o
);

  logic [NUM_IRQ-1:0] src_q, src_d;
  logic [NUM_IRQ-1:0] src_qq, src_qd;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               int_q, int_d;
  logic [NUM_IRQ-1:0] rise;

  always_comb begin
    src_d  = irq_src;
    src_qd = src_q;
    rise   = src_q & ~src_qq;
    pend_d = pend_q;
    if (pend_clr_we) pend_d = pend_d & ~wdata;
    // a new edge beats a same-cycle clear
    pend_d = pend_d | rise;
    mask_d = mask_we ? wdata : mask_q;
    int_d  = |(pend_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      src_qq <= '0;
      pend_q <= '0;
      mask_q <= '0;
      int_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      src_qq <= src_qd;
      pend_q <= pend_d;
      mask_q <= mask_d;
      int_q  <= int_d;
    end
  end

  assign pending = pend_q;
  assign mask    = mask_q;
  assign int_o   = int_q;

endmodule

// File: rtl/rat_io_hub.sv
// RAT CPU port-I/O hub: input mux, output bank, VGA write port, IRQs.
// Define RAT_IO_VGA_AUTOINC_EN to step the pixel address after each write.
module rat_io_hub
  import rat_io_pkg::*;
#(
  parameter int         NUM_IN   = 4,
  parameter int         NUM_OUT  = 4,
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] IN_BASE  = 8'h20,
  parameter logic [7:0] OUT_BASE = 8'h40,
  parameter int         VGA_XMAX = 80,
  parameter int         VGA_YMAX = 60
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            PORT_ID,
  input  logic [7:0]            OUT_PORT,
  input  logic                  IO_STRB,
  output logic [7:0]            IN_PORT,
  input  logic [8*NUM_IN-1:0]   IN_DATA,
  output logic [8*NUM_OUT-1:0]  OUT_DATA,
  output logic [VGA_AW-1:0]     VGA_WA,
  output logic [7:0]            VGA_WD,
  output logic                  VGA_WE,
  input  logic [7:0]            VGA_RD,
  input  logic [NUM_IRQ-1:0]    IRQ_SRC,
  output logic                  INT
);

  logic                           strb_q, strb_d;
  logic                           wr_ev;
  logic [NUM_OUT-1:0][7:0]        out_q, out_d;
  logic [VGA_XW-1:0]              x_q, x_d;
  logic [VGA_YW-1:0]              y_q, y_d;
  logic [7:0]                     wd_q, wd_d;
  logic                           we_q, we_d;
  logic [NUM_IRQ-1:0]             pending, mask;
  logic [7:0]                     rd;

  assign wr_ev = IO_STRB & ~strb_q;

  always_comb begin
    strb_d = IO_STRB;
    out_d  = out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_ev && PORT_ID == OUT_BASE + 8'(k)) out_d[k] = OUT_PORT;
    end
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    wd_d = wd_q;
    we_d = 1'b0;
`ifdef RAT_IO_VGA_AUTOINC_EN
    if (we_q) begin
      if (x_q == VGA_XW'(VGA_XMAX - 1)) begin
        x_d = '0;
        y_d = (y_q == VGA_YW'(VGA_YMAX - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
`endif
    if (wr_ev) begin
      unique case (PORT_ID)
        VGA_HADDR_ID: y_d = OUT_PORT[VGA_YW-1:0];
        VGA_LADDR_ID: x_d = OUT_PORT[VGA_XW-1:0];
        VGA_COLOR_ID: begin
          wd_d = OUT_PORT;
          we_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  rat_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk        (CLK),
    .rst        (RST),
    .irq_src    (IRQ_SRC),
    .pend_clr_we(wr_ev && PORT_ID == IRQ_PEND_ID),
    .mask_we    (wr_ev && PORT_ID == IRQ_MASK_ID),
    .wdata      (OUT_PORT[NUM_IRQ-1:0]),
    .pending    (pending),
    .mask       (mask),
    .int_o      (INT)
  );

  always_comb begin
    rd = 8'h00;
    unique case (PORT_ID)
      VGA_READ_ID: rd = VGA_RD;
      IRQ_PEND_ID: rd[NUM_IRQ-1:0] = pending;
      IRQ_MASK_ID: rd[NUM_IRQ-1:0] = mask;
      default: ;
    endcase
    for (int k = 0; k < NUM_IN; k++) begin
      if (PORT_ID == IN_BASE + 8'(k)) rd = IN_DATA[8*k +: 8];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (PORT_ID == OUT_BASE + 8'(k)) rd = out_q[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strb_q <= 1'b0;
      out_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
    end else begin
      strb_q <= strb_d;
      out_q  <= out_d;
      x_q    <= x_d;
      y_q    <= y_d;
      wd_q   <= wd_d;
      we_q   <= we_d;
    end
  end

  assign IN_PORT  = rd;
  assign OUT_DATA = out_q;
  assign VGA_WA   = {y_q, x_q};
  assign VGA_WD   = wd_q;
  assign VGA_WE   = we_q;

endmodule

// File: tb/tb_rat_io_hub.sv
// Self-checking bench for rat_io_hub; VGA writes go through a scoreboard.
// Expected VGA addresses follow RAT_IO_VGA_AUTOINC_EN when it is defined.
module tb_rat_io_hub;
  import rat_io_pkg::*;

  localparam int         NUM_IN   = 4;
  localparam int         NUM_OUT  = 4;
  localparam int         NUM_IRQ  = 4;
  localparam logic [7:0] IN_BASE  = 8'h20;
  localparam logic [7:0] OUT_BASE = 8'h40;
  localparam int         XMAX     = 80;
  localparam int         YMAX     = 60;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           port_id, out_port, in_port, vga_wd, vga_rd;
  logic                 io_strb, vga_we, int_o;
  logic [8*NUM_IN-1:0]  in_data;
  logic [8*NUM_OUT-1:0] out_data;
  logic [12:0]          vga_wa;
  logic [NUM_IRQ-1:0]   irq_src;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [20:0] vga_q[$];
  logic [7:0]  exp_out[NUM_OUT];
  logic [7:0]  in_vals[NUM_IN];
  int          mx, my;

  always #5 clk = ~clk;

  rat_io_hub #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .NUM_IRQ(NUM_IRQ),
    .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE),
    .VGA_XMAX(XMAX), .VGA_YMAX(YMAX)
  ) dut (
    .CLK(clk), .RST(rst), .PORT_ID(port_id), .OUT_PORT(out_port),
    .IO_STRB(io_strb), .IN_PORT(in_port), .IN_DATA(in_data),
    .OUT_DATA(out_data), .VGA_WA(vga_wa), .VGA_WD(vga_wd),
    .VGA_WE(vga_we), .VGA_RD(vga_rd), .IRQ_SRC(irq_src), .INT(int_o)
  );

  initial begin
    assert (IN_BASE + NUM_IN <= OUT_BASE || OUT_BASE + NUM_OUT <= IN_BASE)
      else $fatal(1, "port ranges overlap");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vga_we === 1'b1) begin
      if (vga_q.size() == 0) check("vga_spurious_we", 32'd1, 32'd0);
      else check("vga_wr", {11'b0, vga_wa, vga_wd}, {11'b0, vga_q.pop_front()});
    end
  end

  function automatic logic [31:0] out_model();
    return {exp_out[3], exp_out[2], exp_out[1], exp_out[0]};
  endfunction

  task automatic wr(logic [7:0] id, logic [7:0] d);
    @(negedge clk);
    port_id = id; out_port = d; io_strb = 1'b1;
    @(negedge clk);
    io_strb = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(logic [7:0] id, logic [7:0] exp, string tag);
    port_id = id;
    #1;
    check(tag, {24'b0, in_port}, {24'b0, exp});
  endtask

  task automatic color(logic [7:0] d);
    vga_q.push_back({my[5:0], mx[6:0], d});
    wr(VGA_COLOR_ID, d);
`ifdef RAT_IO_VGA_AUTOINC_EN
    if (mx == XMAX - 1) begin
      mx = 0;
      my = (my == YMAX - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
`endif
  endtask

  task automatic irq_pulse(logic [NUM_IRQ-1:0] s);
    @(negedge clk); irq_src = s;
    @(negedge clk); irq_src = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
    irq_src = '0; vga_rd = 8'h3C;
    for (int k = 0; k < NUM_IN; k++) in_vals[k] = 8'(8'h11 * (k + 1));
    in_data = {in_vals[3], in_vals[2], in_vals[1], in_vals[0]};
    for (int k = 0; k < NUM_OUT; k++) exp_out[k] = 8'h00;
    mx = 0; my = 0;
    repeat (2) @(negedge clk);
    check("rst_out", out_data, 32'h0);
    check("rst_wa", {19'b0, vga_wa}, 32'h0);
    check("rst_wd", {24'b0, vga_wd}, 32'h0);
    check("rst_we", {31'b0, vga_we}, 32'h0);
    check("rst_int", {31'b0, int_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd(IRQ_PEND_ID, 8'h00, "rst_pend");
    rd(IRQ_MASK_ID, 8'h00, "rst_mask");

    for (int k = 0; k < NUM_IN; k++) rd(IN_BASE + 8'(k), in_vals[k], "in_ch");
    in_data = $urandom;
    for (int k = 0; k < NUM_IN; k++) in_vals[k] = in_data[8*k +: 8];
    for (int k = 0; k < NUM_IN; k++) rd(IN_BASE + 8'(k), in_vals[k], "in_ch_new");

    @(negedge clk);
    port_id = 8'h41; out_port = 8'hA5; io_strb = 1'b1;
    @(negedge clk);
    out_port = 8'h5A;
    @(negedge clk);
    io_strb = 1'b0;
    @(negedge clk);
    exp_out[1] = 8'hA5;
    check("strb_once", out_data, out_model());
    rd(8'h41, 8'hA5, "rdback_41");
    rd(8'h7F, 8'h00, "unmapped_7f");
    rd(OUT_BASE + 8'(NUM_OUT), 8'h00, "out_past_end");

    for (int k = 0; k < NUM_OUT; k++) begin
      exp_out[k] = 8'($urandom);
      wr(OUT_BASE + 8'(k), exp_out[k]);
    end
    wr(OUT_BASE + 8'(NUM_OUT), 8'hEE);
    check("out_bank", out_data, out_model());
    for (int k = 0; k < NUM_OUT; k++) rd(OUT_BASE + 8'(k), exp_out[k], "rdback");

    wr(VGA_HADDR_ID, 8'h05); my = 5;
    wr(VGA_LADDR_ID, 8'h4F); mx = 8'h4F;
    color(8'h1C);
    check("vga_we_low", {31'b0, vga_we}, 32'h0);
    check("vga_wd", {24'b0, vga_wd}, 32'h1C);
    check("vga_wa", {19'b0, vga_wa}, 32'({my[5:0], mx[6:0]}));
    rd(VGA_READ_ID, 8'h3C, "vga_rd");

    wr(VGA_HADDR_ID, 8'd59); my = 59;
    wr(VGA_LADDR_ID, 8'd79); mx = 79;
    color(8'h01);
    color(8'h02);
    color(8'h03);
    check("vga_wa_end", {19'b0, vga_wa}, 32'({my[5:0], mx[6:0]}));

    wr(IRQ_MASK_ID, 8'hFF);
    rd(IRQ_MASK_ID, 8'h0F, "mask_width");
    wr(IRQ_MASK_ID, 8'h05);
    rd(IRQ_MASK_ID, 8'h05, "mask_05");
    irq_pulse(4'b0100);
    check("int_not_yet", {31'b0, int_o}, 32'h0);
    rd(IRQ_PEND_ID, 8'h04, "pend_04");
    @(negedge clk);
    check("int_high", {31'b0, int_o}, 32'h1);
    irq_pulse(4'b0010);
    @(negedge clk);
    rd(IRQ_PEND_ID, 8'h06, "pend_06");
    check("int_kept", {31'b0, int_o}, 32'h1);
    wr(IRQ_PEND_ID, 8'h04);
    check("int_cleared", {31'b0, int_o}, 32'h0);
    rd(IRQ_PEND_ID, 8'h02, "pend_02");

    @(negedge clk); irq_src = 4'b0001;
    @(negedge clk);
    port_id = IRQ_PEND_ID; out_port = 8'h01; io_strb = 1'b1;
    @(negedge clk); io_strb = 1'b0; irq_src = '0;
    rd(IRQ_PEND_ID, 8'h03, "set_wins");
    @(negedge clk);
    check("int_set_wins", {31'b0, int_o}, 32'h1);
    wr(IRQ_PEND_ID, 8'h0F);
    rd(IRQ_PEND_ID, 8'h00, "pend_all_clr");

    @(negedge clk);
    port_id = 8'h42; out_port = 8'h77; io_strb = 1'b1;
    @(negedge clk);
    exp_out[2] = 8'h77;
    check("pre_rst_wr", out_data, out_model());
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NUM_OUT; k++) exp_out[k] = 8'h00;
    mx = 0; my = 0;
    check("mid_rst_out", out_data, 32'h0);
    check("mid_rst_wa", {19'b0, vga_wa}, 32'h0);
    check("mid_rst_wd", {24'b0, vga_wd}, 32'h0);
    check("mid_rst_int", {31'b0, int_o}, 32'h0);
    rd(IRQ_MASK_ID, 8'h00, "mid_rst_mask");
    port_id = 8'h42; out_port = 8'h88; rst = 1'b0;
    @(negedge clk);
    exp_out[2] = 8'h88;
    check("post_rst_wr", out_data, out_model());
    out_port = 8'h99;
    @(negedge clk);
    check("post_rst_once", out_data, out_model());
    io_strb = 1'b0;
    repeat (2) @(negedge clk);

    check("vga_q_empty", vga_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
